// File: rtl/seq_pattern_detector_if.sv
// Serial-bit handshake and status bundle for the pattern detector.
// CNT_W must match the CNT_W of the detector instance it connects to.
interface seq_pattern_detector_if #(
    parameter int CNT_W = 8
);
    logic             clear;
    logic             din_valid;
    logic             din;
    logic             pattern_detect;
    logic [CNT_W-1:0] match_count;
    logic [5:0]       progress;

    modport master (
        output clear, din_valid, din,
        input  pattern_detect, match_count, progress
    );

    modport slave (
        input  clear, din_valid, din,
        output pattern_detect, match_count, progress
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector: matches the last LEN qualified bits
// against PATTERN, with overlap mode, inter-bit timeout and saturating count.
module seq_pattern_detector #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             TIMEOUT = 16,
    parameter int             CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_pattern_detector_if.slave  bus
);
    localparam int         IW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [5:0] FULL = 6'(LEN);

    logic [LEN-1:0]   r_hist;
    logic [5:0]       r_fill;
    logic [IW-1:0]    r_idle;
    logic             r_det;
    logic [CNT_W-1:0] r_cnt;

    logic [LEN-1:0]   w_nh;
    logic [5:0]       w_nf;
    logic             w_match;
    logic [IW-1:0]    w_idle_nxt;
    logic             w_timeout;

    // Truncating the concatenation drops the oldest bit; also valid for LEN=1.
    always_comb begin
        w_nh       = LEN'({r_hist, bus.din});
        w_nf       = (r_fill == FULL) ? r_fill : r_fill + 6'd1;
        w_match    = (w_nf == FULL) && (w_nh == PATTERN);
        w_idle_nxt = r_idle + 1'b1;
        w_timeout  = (TIMEOUT > 0) && (w_idle_nxt == IW'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_idle <= '0;
            r_det  <= 1'b0;
            r_cnt  <= '0;
        end else if (bus.clear) begin
            r_hist <= '0;
            r_fill <= '0;
            r_idle <= '0;
            r_det  <= 1'b0;
            r_cnt  <= '0;
        end else if (bus.din_valid) begin
            r_idle <= '0;
            r_det  <= w_match;
            if (w_match) begin
                if (r_cnt != '1)
                    r_cnt <= r_cnt + 1'b1;
                if (OVERLAP != 0) begin
                    r_hist <= w_nh;
                    r_fill <= FULL;
                end else begin
                    r_hist <= '0;
                    r_fill <= '0;
                end
            end else begin
                r_hist <= w_nh;
                r_fill <= w_nf;
            end
        end else begin
            r_det <= 1'b0;
            // Idle only ages a partial history; an empty one has nothing to discard.
            if ((TIMEOUT > 0) && (r_fill != 6'd0)) begin
                if (w_timeout) begin
                    r_hist <= '0;
                    r_fill <= '0;
                    r_idle <= '0;
                end else begin
                    r_idle <= w_idle_nxt;
                end
            end
        end
    end

    assign bus.pattern_detect = r_det;
    assign bus.match_count    = r_cnt;
    assign bus.progress       = r_fill;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three configurations driven in lockstep,
// checked every cycle against a queue-based model plus directed literals.
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr = 1'b0, dv = 1'b0, din = 1'b0;

    always #5 clk = ~clk;

    seq_pattern_detector_if #(.CNT_W(8)) ifa ();
    seq_pattern_detector_if #(.CNT_W(8)) ifb ();
    seq_pattern_detector_if #(.CNT_W(2)) ifc ();

    assign ifa.clear = clr; assign ifa.din_valid = dv; assign ifa.din = din;
    assign ifb.clear = clr; assign ifb.din_valid = dv; assign ifb.din = din;
    assign ifc.clear = clr; assign ifc.din_valid = dv; assign ifc.din = din;

    seq_pattern_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .TIMEOUT(16), .CNT_W(8))
        u_ovl (.clk(clk), .reset(reset), .bus(ifa));
    seq_pattern_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .TIMEOUT(16), .CNT_W(8))
        u_nov (.clk(clk), .reset(reset), .bus(ifb));
    seq_pattern_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .TIMEOUT(16), .CNT_W(2))
        u_c2  (.clk(clk), .reset(reset), .bus(ifc));

    int tests = 0;
    int fails = 0;
    int det_seen = 0;

    // Model: received bits since the last discard, plus counters.
    bit  mq[3][$];
    int  midle[3];
    int  mcnt[3];
    bit  mdet[3];
    int  cmax[3] = '{255, 255, 3};
    bit  movl[3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] pat = 4'b1011;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic mstep(input int k, input bit rs, input bit c, input bit v, input bit d);
        bit t[$];
        bit m;
        int n;
        t = mq[k];
        if (rs || c) begin
            t.delete(); midle[k] = 0; mdet[k] = 0; mcnt[k] = 0;
        end else if (v) begin
            t.push_back(d);
            midle[k] = 0;
            n = t.size();
            m = (n >= 4);
            if (m)
                for (int i = 0; i < 4; i++)
                    if (t[n-4+i] != pat[3-i]) m = 0;
            mdet[k] = m;
            if (m) begin
                if (mcnt[k] < cmax[k]) mcnt[k]++;
                if (!movl[k]) t.delete();
            end
            if (t.size() > 8) void'(t.pop_front());
        end else begin
            mdet[k] = 0;
            if (t.size() > 0) begin
                midle[k]++;
                if (midle[k] == 16) begin t.delete(); midle[k] = 0; end
            end
        end
        mq[k] = t;
    endtask

    function automatic int exp_prog(input int k);
        return (mq[k].size() > 4) ? 4 : mq[k].size();
    endfunction

    // Per-cycle compare process.
    initial begin
        bit rs, c, v, d;
        forever begin
            @(posedge clk);
            rs = reset; c = clr; v = dv; d = din;
            for (int k = 0; k < 3; k++) mstep(k, rs, c, v, d);
            #1;
            chk("ovl.detect",   int'(ifa.pattern_detect), int'(mdet[0]));
            chk("ovl.count",    int'(ifa.match_count),    mcnt[0]);
            chk("ovl.progress", int'(ifa.progress),       exp_prog(0));
            chk("nov.detect",   int'(ifb.pattern_detect), int'(mdet[1]));
            chk("nov.count",    int'(ifb.match_count),    mcnt[1]);
            chk("nov.progress", int'(ifb.progress),       exp_prog(1));
            chk("c2.detect",    int'(ifc.pattern_detect), int'(mdet[2]));
            chk("c2.count",     int'(ifc.match_count),    mcnt[2]);
            chk("c2.progress",  int'(ifc.progress),       exp_prog(2));
            if (ifa.pattern_detect) det_seen++;
        end
    end

    task automatic send(input bit b);
        @(negedge clk); clr = 1'b0; dv = 1'b1; din = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); clr = 1'b0; dv = 1'b0; end
    endtask

    task automatic clear_pulse();
        @(negedge clk); clr = 1'b1; dv = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk); #2;
    endtask

    initial begin
        int ce[5] = '{1, 2, 3, 3, 3};
        repeat (2) @(negedge clk);
        chk("reset.progress", int'(ifa.progress), 0);
        chk("reset.count",    int'(ifa.match_count), 0);
        reset = 1'b0;

        // Single match
        send(1); send(0); send(1); send(1); after_edge();
        chk("single.detect",   int'(ifa.pattern_detect), 1);
        chk("single.count",    int'(ifa.match_count), 1);
        chk("single.progress", int'(ifa.progress), 4);

        // Overlap vs non-overlap on 1011011
        clear_pulse();
        send(1); send(0); send(1); send(1); send(0); send(1); send(1); after_edge();
        chk("ovl.two_matches", int'(ifa.match_count), 2);
        chk("ovl.last_detect", int'(ifa.pattern_detect), 1);
        chk("nov.one_match",   int'(ifb.match_count), 1);
        chk("nov.progress3",   int'(ifb.progress), 3);
        chk("nov.no_detect",   int'(ifb.pattern_detect), 0);

        // 15 idle cycles keep the partial history
        clear_pulse();
        send(1); send(0); send(1); idle(15); send(1); after_edge();
        chk("idle15.detect", int'(ifa.pattern_detect), 1);

        // 16 idle cycles discard it
        clear_pulse();
        send(1); send(0); send(1); idle(16); after_edge();
        chk("idle16.progress0", int'(ifa.progress), 0);
        send(1); after_edge();
        chk("idle16.no_detect", int'(ifa.pattern_detect), 0);
        chk("idle16.progress1", int'(ifa.progress), 1);

        // Reset mid-sequence
        send(1); send(0); send(1);
        @(negedge clk); reset = 1'b1; dv = 1'b0;
        @(negedge clk); reset = 1'b0;
        send(1); after_edge();
        chk("rst_mid.no_detect", int'(ifa.pattern_detect), 0);
        chk("rst_mid.progress",  int'(ifa.progress), 1);

        // Clear wins over a valid final bit
        send(1); send(0); send(1);
        @(negedge clk); clr = 1'b1; dv = 1'b1; din = 1'b1;
        after_edge();
        chk("clr_final.no_detect", int'(ifa.pattern_detect), 0);
        chk("clr_final.count",     int'(ifa.match_count), 0);
        chk("clr_final.progress",  int'(ifa.progress), 0);

        // Five matches: the 2-bit counter saturates, pulses continue
        clear_pulse();
        det_seen = 0;
        send(1); send(0); send(1); send(1); after_edge();
        chk("sat.count0", int'(ifc.match_count), ce[0]);
        for (int i = 1; i < 5; i++) begin
            send(0); send(1); send(1); after_edge();
            chk("sat.count", int'(ifc.match_count), ce[i]);
            chk("sat.pulse", int'(ifc.pattern_detect), 1);
        end
        chk("sat.ovl_count", int'(ifa.match_count), 5);
        idle(2); after_edge();
        chk("sat.pulses", det_seen, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
